half_adder_unit: RTL and testbench
==================================

// Module: half_adder_unit
// PURPOSE
//   Registered, lane-parallel half adder: per lane, sum S = a XOR b, carry C = a AND b.
//   Leaf arithmetic primitive for adder trees and increment logic; one clock domain.
//   Outputs are registered with a valid qualifier so the block drops into pipelined datapaths.
// PARAMETERS
//   WIDTH      1    number of independent 1-bit half-adder lanes (WIDTH >= 1)
//   CNT_W      16   width of carry-event statistics counter (optional feature only)
// PORTS
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous, active-high reset
//   a          in   WIDTH     operand A, one bit per lane
//   b          in   WIDTH     operand B, one bit per lane
//   in_valid   in   1         a/b are valid this cycle
//   S          out  WIDTH     registered sum, lane i = a[i] ^ b[i]
//   C          out  WIDTH     registered carry, lane i = a[i] & b[i]
//   out_valid  out  1         S/C hold a valid result
//   carry_cnt  out  CNT_W     saturating count of lanes that produced a carry (see CONFIGURATION)
// BEHAVIOUR
//   - Clock/reset: single clock clk; reset rst is synchronous and active-high.
//   - Reset: on the first rising edge with rst=1: S=0, C=0, out_valid=0, carry_cnt=0.
//   - Reset has priority over in_valid in the same cycle; inputs sampled that edge are discarded.
//   - Latency 1 cycle: in_valid=1 at edge N -> S/C updated and out_valid=1 after edge N.
//   - in_valid=0 at an edge: out_valid=0 after that edge; S/C hold their last values (no clear).
//   - No backpressure: a new result may be accepted every cycle; no ready signal.
//   - Arithmetic per lane is exact: {C[i],S[i]} == a[i] + b[i]; lanes never interact.
//   - S and C are never both 1 in the same lane; test asserts this.
//   - X on a/b with in_valid=0 must not change S/C.
// CONFIGURATION
//   Macro HALF_ADDER_UNIT_STATS_EN:
//   - Defined: carry_cnt increments, on every edge with in_valid=1 and rst=0, by popcount(a & b)
//     over all lanes; saturates at 2**CNT_W-1 (no wrap); cleared only by rst.
//   - Not defined: carry_cnt is driven constant 0; no counter logic synthesised; port remains.
//   - S, C, out_valid timing identical in both configurations.
// TESTING
//   1. rst=1 for 2 cycles with a=1,b=1,in_valid=1 -> S=0,C=0,out_valid=0,carry_cnt=0 throughout.
//   2. WIDTH=1, in_valid=1, apply (a,b)=(0,0),(1,0),(0,1),(1,1) on consecutive cycles ->
//      one cycle later (S,C)=(0,0),(1,0),(1,0),(0,1), out_valid=1 each cycle.
//   3. After (1,1) drop in_valid -> out_valid=0 next cycle, S=0,C=1 held.
//   4. WIDTH=4, a=4'b1100, b=4'b1010 -> S=4'b0110, C=4'b1000 after 1 cycle.
//   5. STATS_EN, WIDTH=4, a=b=4'b1111 for 3 cycles -> carry_cnt=12; without macro carry_cnt=0.
//   6. STATS_EN, CNT_W=4, a=b=1 for 20 cycles -> carry_cnt saturates at 15; rst mid-run clears all outputs next edge.

Source files
------------

// File: rtl/half_adder_unit.sv
// -----------------------------------------------------------------------------
// half_adder_unit
//   Registered, lane-parallel half adder. Each of the WIDTH lanes computes
//   S = a ^ b and C = a & b independently. There is one register stage, and a
//   valid flag travels with the data, so the block fits into pipelined
//   datapaths (adder trees, increment logic).
//
// Configuration macro:
//   HALF_ADDER_UNIT_STATS_EN  When defined, carry_cnt is a saturating counter of
//                             carry-producing lanes. It adds popcount(a & b) on
//                             every accepted input and is cleared only by rst.
//                             When undefined, carry_cnt is tied to zero and no
//                             counter logic exists.
//
// Parameters:
//   WIDTH  number of independent 1-bit half-adder lanes (>= 1)
//   CNT_W  width of the carry-event counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears S, C, out_valid, carry_cnt)
//   a, b       operands, one bit per lane
//   in_valid   a/b are valid this cycle
//   S, C       registered sum / carry per lane (held while in_valid=0)
//   out_valid  S/C were loaded on the last edge
//   carry_cnt  saturating carry-event count (zero unless stats enabled)
// -----------------------------------------------------------------------------
module half_adder_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  logic [WIDTH-1:0] s_p1;
  logic [WIDTH-1:0] c_p1;
  logic             vld_p1;

  // ---- stage p0 -> p1: lane-wise half add, loaded only on valid input ----
  // The result registers are cleared on reset so that S/C read as zero
  // afterwards. Without a valid input they hold their value, so that
  // don't-care operands never reach S/C.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      s_p1   <= '0;
      c_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        s_p1 <= a ^ b;
        c_p1 <= a & b;
      end
    end
  end

  assign S         = s_p1;
  assign C         = c_p1;
  assign out_valid = vld_p1;

`ifdef HALF_ADDER_UNIT_STATS_EN
  localparam int PC_W  = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] x);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PC_W'(x[i]);
    end
    return n;
  endfunction

  // The sum is widened by one bit so that overflow is visible and the
  // counter clamps instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(inc);
    if (sum > CNT_MAX) begin
      return CNT_MAX[CNT_W-1:0];
    end
    return sum[CNT_W-1:0];
  endfunction

  // ---- stage p0 -> p1: carry-event statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (in_valid) begin
      cnt_p1 <= sat_add(cnt_p1, popcount(a & b));
    end
  end

  assign carry_cnt = cnt_p1;
`else
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder_unit.sv
// -----------------------------------------------------------------------------
// tb_half_adder_unit
//   Drives two instances from a shared rst/in_valid:
//     d1: WIDTH=1, CNT_W=4  (truth table, counter saturation at 15)
//     d4: WIDTH=4, CNT_W=16 (multi-lane operation, carry counting)
//   A behavioural model tracks the expected state from lane-wise integer
//   addition. After each clock edge, every output is compared with the model.
//   Build with or without HALF_ADDER_UNIT_STATS_EN; the expected counter
//   value follows the same macro.
// -----------------------------------------------------------------------------
module tb_half_adder_unit;

`ifdef HALF_ADDER_UNIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1, s1, c1;
  logic [3:0] a4, b4, s4, c4;
  logic       v1, v4;
  logic [3:0]  cnt1;
  logic [15:0] cnt4;

  int checks = 0;
  int errors = 0;

  // model state
  int m1_s, m1_c, m1_v, m1_cnt;
  int m4_s, m4_c, m4_v, m4_cnt;

  always #5 clk = ~clk;

  half_adder_unit #(.WIDTH(1), .CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
    .S(s1), .C(c1), .out_valid(v1), .carry_cnt(cnt1)
  );

  half_adder_unit #(.WIDTH(4), .CNT_W(16)) d4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(in_valid),
    .S(s4), .C(c4), .out_valid(v4), .carry_cnt(cnt4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Lane-by-lane integer addition: the model knows nothing about XOR/AND.
  task automatic model_lane_add(input int w, input int av, input int bv,
                                output int s, output int c, output int ncarry);
    s = 0; c = 0; ncarry = 0;
    for (int i = 0; i < w; i++) begin
      int sum;
      sum = ((av >> i) & 1) + ((bv >> i) & 1);
      s += (sum % 2) << i;
      c += (sum / 2) << i;
      if (sum == 2) ncarry++;
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int w, input int cmax,
                            input int av, input int bv,
                            inout int ms, inout int mc, inout int mv, inout int mcnt);
    int s, c, n;
    if (r) begin
      ms = 0; mc = 0; mv = 0; mcnt = 0;
    end else if (v) begin
      model_lane_add(w, av, bv, s, c, n);
      ms = s; mc = c; mv = 1;
      if (STATS) mcnt = (mcnt + n > cmax) ? cmax : mcnt + n;
    end else begin
      mv = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [0:0] ia1,
                       input logic [0:0] ib1, input logic [3:0] ia4,
                       input logic [3:0] ib4);
    rst = r; in_valid = v; a1 = ia1; b1 = ib1; a4 = ia4; b4 = ib4;
    @(posedge clk);
    model_step(r, v, 1, 15, int'(ia1), int'(ib1), m1_s, m1_c, m1_v, m1_cnt);
    model_step(r, v, 4, 65535, int'(ia4), int'(ib4), m4_s, m4_c, m4_v, m4_cnt);
    #1;
    check_eq("d1_S",    32'(s1),    32'(m1_s));
    check_eq("d1_C",    32'(c1),    32'(m1_c));
    check_eq("d1_vld",  32'(v1),    32'(m1_v));
    check_eq("d1_cnt",  32'(cnt1),  32'(m1_cnt));
    check_eq("d1_excl", 32'(s1 & c1), 32'd0);
    check_eq("d4_S",    32'(s4),    32'(m4_s));
    check_eq("d4_C",    32'(c4),    32'(m4_c));
    check_eq("d4_vld",  32'(v4),    32'(m4_v));
    check_eq("d4_cnt",  32'(cnt4),  32'(m4_cnt));
    check_eq("d4_excl", 32'(s4 & c4), 32'd0);
  endtask

  initial begin
    m1_s = 0; m1_c = 0; m1_v = 0; m1_cnt = 0;
    m4_s = 0; m4_c = 0; m4_v = 0; m4_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    @(negedge clk);

    // Reset dominates valid operands for two cycles.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
      check_eq("rst_S",   32'(s1), 32'd0);
      check_eq("rst_C",   32'(c1), 32'd0);
      check_eq("rst_vld", 32'(v1), 32'd0);
      check_eq("rst_cnt", 32'(cnt4), 32'd0);
    end

    // Truth table on d1; the d4 lanes use 1100 + 1010 on the first cycle.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 4'b1010);
    check_eq("tt00", 32'({c1, s1}), 32'd0);
    check_eq("w4_S", 32'(s4), 32'b0110);
    check_eq("w4_C", 32'(c4), 32'b1000);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    check_eq("tt10", 32'({c1, s1}), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    check_eq("tt01", 32'({c1, s1}), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    check_eq("tt11", 32'({c1, s1}), 32'd2);
    check_eq("tt_vld", 32'(v1), 32'd1);

    // Drop valid with changed operands: outputs hold and valid falls.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0011);
    check_eq("hold_vld", 32'(v1), 32'd0);
    check_eq("hold_SC",  32'({c1, s1}), 32'd2);

    // Carry counting: 4 carries x 3 cycles after reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
    check_eq("cnt12", 32'(cnt4), STATS ? 32'd12 : 32'd0);

    // Saturation of the 4-bit counter, then a mid-run reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h1);
    check_eq("sat15", 32'(cnt1), STATS ? 32'd15 : 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
    check_eq("mid_rst_cnt", 32'(cnt1), 32'd0);
    check_eq("mid_rst_SC",  32'({c1, s1}), 32'd0);
    check_eq("mid_rst_vld", 32'(v1), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the stimulus is finite, but guard against a stalled clock.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
